// File: rtl/uart_pkg.sv
// Shared UART definitions: frame states, line levels, parity encodings and latched frame config.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam logic UART_IDLE_LVL = 1'b1;
  localparam logic START_LVL     = 1'b0;
  localparam logic STOP_LVL      = 1'b1;
  localparam logic PARITY_EVEN   = 1'b0;
  localparam logic PARITY_ODD    = 1'b1;

  typedef struct packed {
    logic parity_enable;
    logic parity_type;
  } frame_cfg_t;

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period counter: counts 0..N-1 while enabled and strobes on the terminal count.
module uart_baud_counter #(
  parameter int unsigned DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_load,
  input  logic                 i_en,
  input  logic [DIV_WIDTH-1:0] i_clks_per_bit,
  output logic                 o_bit_tick_c
);

  logic [DIV_WIDTH-1:0] r_cnt;
  logic [DIV_WIDTH-1:0] r_term;

  // Terminal count is N-1, with a divisor of 0 behaving as 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_term <= '0;
    end else if (i_load) begin
      r_cnt  <= '0;
      r_term <= (i_clks_per_bit == '0) ? '0 : i_clks_per_bit - DIV_WIDTH'(1);
    end else if (i_en) begin
      r_cnt  <= o_bit_tick_c ? '0 : r_cnt + DIV_WIDTH'(1);
    end
  end

  assign o_bit_tick_c = i_en && (r_cnt == r_term);

endmodule

// File: rtl/uart_tx_scheduler.sv
// Two-requester round-robin UART transmitter: arbitrates in IDLE, then serialises one frame.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DIV_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_parity_enable,
  input  logic                  i_parity_type,
  input  logic [DIV_WIDTH-1:0]  i_clks_per_bit,
  input  logic                  i_req0_valid,
  input  logic [DATA_WIDTH-1:0] i_req0_data,
  output logic                  o_req0_ready,
  input  logic                  i_req1_valid,
  input  logic [DATA_WIDTH-1:0] i_req1_data,
  output logic                  o_req1_ready,
  output logic                  o_tx,
  output logic                  o_busy,
  output logic                  o_grant_id
);

  localparam int unsigned IDX_W = $clog2(DATA_WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  uart_state_e           r_state;
  uart_state_e           w_state_next;
  logic [DATA_WIDTH-1:0] r_data;
  frame_cfg_t            r_cfg;
  logic                  r_rr_ptr;
  logic                  r_grant_id;
  logic [IDX_W-1:0]      r_bit_idx;
  logic [IDX_W-1:0]      w_idx_next;
  logic                  r_tx;
  logic                  w_tx_next;
  logic                  w_accept;
  logic                  w_gnt_id;
  logic                  w_bit_tick;

  // Round robin: with both requesting, the pointer (the one not granted last) wins.
  assign w_gnt_id = (i_req0_valid && i_req1_valid) ? r_rr_ptr : i_req1_valid;
  assign w_accept = (r_state == IDLE) && (i_req0_valid || i_req1_valid);

  uart_baud_counter #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_baud (
    .clk           (clk),
    .rst           (rst),
    .i_load        (w_accept),
    .i_en          (r_state != IDLE),
    .i_clks_per_bit(i_clks_per_bit),
    .o_bit_tick_c  (w_bit_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_next = START;
      START:   if (w_bit_tick) w_state_next = DATA;
      DATA: begin
        if (w_bit_tick && (r_bit_idx == LAST_IDX))
          w_state_next = r_cfg.parity_enable ? PARITY : STOP;
      end
      PARITY:  if (w_bit_tick) w_state_next = STOP;
      STOP:    if (w_bit_tick) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Line level is computed for the upcoming state so o_tx can be a plain register.
  always_comb begin
    w_idx_next   = r_bit_idx;
    w_tx_next    = UART_IDLE_LVL;
    o_req0_ready = w_accept && !w_gnt_id && !rst;
    o_req1_ready = w_accept &&  w_gnt_id && !rst;
    if (r_state == IDLE) begin
      w_idx_next = '0;
    end else if ((r_state == DATA) && w_bit_tick) begin
      w_idx_next = (r_bit_idx == LAST_IDX) ? '0 : r_bit_idx + IDX_W'(1);
    end
    case (w_state_next)
      IDLE:    w_tx_next = UART_IDLE_LVL;
      START:   w_tx_next = START_LVL;
      DATA:    w_tx_next = r_data[w_idx_next];
      PARITY:  w_tx_next = (^r_data) ^ r_cfg.parity_type;
      STOP:    w_tx_next = STOP_LVL;
      default: w_tx_next = UART_IDLE_LVL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data     <= '0;
      r_cfg      <= '{parity_enable: 1'b0, parity_type: PARITY_EVEN};
      r_rr_ptr   <= 1'b0;
      r_grant_id <= 1'b0;
      r_bit_idx  <= '0;
      r_tx       <= UART_IDLE_LVL;
    end else begin
      r_bit_idx <= w_idx_next;
      r_tx      <= w_tx_next;
      if (w_accept) begin
        r_data     <= w_gnt_id ? i_req1_data : i_req0_data;
        r_cfg      <= '{parity_enable: i_parity_enable, parity_type: i_parity_type};
        r_grant_id <= w_gnt_id;
        r_rr_ptr   <= !w_gnt_id;
      end
    end
  end

  assign o_tx       = r_tx;
  assign o_busy     = (r_state != IDLE);
  assign o_grant_id = r_grant_id;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: vector table of frames plus arbitration and reset sequences.
module tb_uart_tx_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_parity_enable;
  logic        i_parity_type;
  logic [15:0] i_clks_per_bit;
  logic        i_req0_valid;
  logic [7:0]  i_req0_data;
  logic        o_req0_ready;
  logic        i_req1_valid;
  logic [7:0]  i_req1_data;
  logic        o_req1_ready;
  logic        o_tx;
  logic        o_busy;
  logic        o_grant_id;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        v0;
    logic [7:0]  d0;
    logic        v1;
    logic [7:0]  d1;
    logic [15:0] n;
    logic        pen;
    logic        pt;
    logic        exp_g;
    logic        exp_par;
    int          exp_len;
  } vec_t;

  vec_t vecs[9];

  uart_tx_scheduler dut (
    .clk            (clk),
    .rst            (rst),
    .i_parity_enable(i_parity_enable),
    .i_parity_type  (i_parity_type),
    .i_clks_per_bit (i_clks_per_bit),
    .i_req0_valid   (i_req0_valid),
    .i_req0_data    (i_req0_data),
    .o_req0_ready   (o_req0_ready),
    .i_req1_valid   (i_req1_valid),
    .i_req1_data    (i_req1_data),
    .o_req1_ready   (o_req1_ready),
    .o_tx           (o_tx),
    .o_busy         (o_busy),
    .o_grant_id     (o_grant_id)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Drives one request, then follows the whole frame cycle by cycle against expected bits.
  task automatic send_frame(input vec_t v, input string tag);
    logic [7:0]  d;
    logic [10:0] bits;
    logic        hs;
    logic        exp_r0;
    logic        exp_r1;
    int          nn;
    int          bad_tx = 0;
    int          bad_rdy = 0;
    int          bad_busy = 0;
    d      = v.exp_g ? v.d1 : v.d0;
    nn     = (v.n == 16'd0) ? 1 : int'(v.n);
    exp_r0 = !v.exp_g;
    exp_r1 = v.exp_g;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = d[i];
    bits[9]  = v.pen ? v.exp_par : 1'b1;
    bits[10] = 1'b1;
    i_clks_per_bit  = v.n;
    i_parity_enable = v.pen;
    i_parity_type   = v.pt;
    i_req0_valid    = v.v0;
    i_req0_data     = v.d0;
    i_req1_valid    = v.v1;
    i_req1_data     = v.d1;
    @(negedge clk);
    chk({tag, "_ready0"}, {31'd0, o_req0_ready}, {31'd0, exp_r0});
    chk({tag, "_ready1"}, {31'd0, o_req1_ready}, {31'd0, exp_r1});
    hs = o_req0_ready || o_req1_ready;
    for (int w = 0; w < 20 && !hs; w++) begin
      @(negedge clk);
      hs = o_req0_ready || o_req1_ready;
    end
    chk({tag, "_handshake"}, {31'd0, hs}, 32'd1);
    if (!hs) begin
      i_req0_valid = 1'b0;
      i_req1_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    i_req0_valid    = 1'b0;
    i_req1_valid    = 1'b0;
    i_req0_data     = ~v.d0;
    i_req1_data     = ~v.d1;
    i_clks_per_bit  = 16'd8;
    i_parity_enable = !v.pen;
    i_parity_type   = !v.pt;
    for (int k = 0; k < v.exp_len; k++) begin
      @(negedge clk);
      if (k == 0) chk({tag, "_grant_id"}, {31'd0, o_grant_id}, {31'd0, v.exp_g});
      if (o_tx !== bits[k / nn]) bad_tx++;
      if (o_req0_ready || o_req1_ready) bad_rdy++;
      if (o_busy !== 1'b1) bad_busy++;
    end
    @(negedge clk);
    chk({tag, "_busy_end"}, {31'd0, o_busy}, 32'd0);
    chk({tag, "_tx_idle"}, {31'd0, o_tx}, 32'd1);
    chk({tag, "_tx_bits_bad"}, 32'(bad_tx), 32'd0);
    chk({tag, "_ready_midframe"}, 32'(bad_rdy), 32'd0);
    chk({tag, "_busy_midframe"}, 32'(bad_busy), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic       order[3];
    logic       gid[3];
    logic       q[$];
    logic [7:0] byte_got;
    logic [7:0] byte_exp;
    int         nrdy;
    int         dbl;
    bit         pend;
    vec_t       rv;

    vecs[0] = '{1'b1, 8'hA5, 1'b0, 8'h00, 16'd4, 1'b0, 1'b0, 1'b0, 1'b0, 40};
    vecs[1] = '{1'b1, 8'h07, 1'b0, 8'h00, 16'd4, 1'b1, 1'b0, 1'b0, 1'b1, 44};
    vecs[2] = '{1'b0, 8'h00, 1'b1, 8'h07, 16'd4, 1'b1, 1'b1, 1'b1, 1'b0, 44};
    vecs[3] = '{1'b1, 8'h3C, 1'b0, 8'h00, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 10};
    vecs[4] = '{1'b0, 8'h00, 1'b1, 8'h00, 16'd1, 1'b1, 1'b0, 1'b1, 1'b0, 11};
    vecs[5] = '{1'b0, 8'h00, 1'b1, 8'hFF, 16'd3, 1'b1, 1'b1, 1'b1, 1'b1, 33};
    vecs[6] = '{1'b1, 8'h80, 1'b0, 8'h00, 16'd2, 1'b0, 1'b0, 1'b0, 1'b0, 20};
    vecs[7] = '{1'b1, 8'h5A, 1'b1, 8'hC3, 16'd1, 1'b0, 1'b0, 1'b1, 1'b0, 10};
    vecs[8] = '{1'b1, 8'h96, 1'b1, 8'h69, 16'd2, 1'b1, 1'b0, 1'b0, 1'b0, 22};

    // Reset state, with both requesters asserting to show readys stay low.
    rst             = 1'b1;
    i_parity_enable = 1'b0;
    i_parity_type   = 1'b0;
    i_clks_per_bit  = 16'd1;
    i_req0_valid    = 1'b1;
    i_req0_data     = 8'h11;
    i_req1_valid    = 1'b1;
    i_req1_data     = 8'h22;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_tx", {31'd0, o_tx}, 32'd1);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_grant", {31'd0, o_grant_id}, 32'd0);
    chk("rst_ready0", {31'd0, o_req0_ready}, 32'd0);
    chk("rst_ready1", {31'd0, o_req1_ready}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Both valid held: expect 0x11, 0x22, 0x11 with alternating grants.
    nrdy = 0;
    dbl  = 0;
    pend = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (pend) begin
        gid[nrdy-1] = o_grant_id;
        pend = 1'b0;
      end
      if (o_busy) q.push_back(o_tx);
      if (o_req0_ready && o_req1_ready) dbl++;
      if ((o_req0_ready || o_req1_ready) && nrdy < 3) begin
        order[nrdy] = o_req1_ready;
        nrdy++;
        pend = 1'b1;
      end
      @(posedge clk);
      #1;
      if (nrdy == 3) begin
        i_req0_valid = 1'b0;
        i_req1_valid = 1'b0;
      end
      if (q.size() >= 30) break;
    end
    chk("rr_handshakes", 32'(nrdy), 32'd3);
    chk("rr_bits_seen", 32'(q.size()), 32'd30);
    chk("rr_double_ready", 32'(dbl), 32'd0);
    if (nrdy == 3) begin
      for (int f = 0; f < 3; f++) begin
        chk($sformatf("rr_order%0d", f), {31'd0, order[f]}, (f == 1) ? 32'd1 : 32'd0);
        chk($sformatf("rr_grant%0d", f), {31'd0, gid[f]}, (f == 1) ? 32'd1 : 32'd0);
      end
    end
    if (q.size() >= 30) begin
      for (int f = 0; f < 3; f++) begin
        for (int i = 0; i < 8; i++) byte_got[i] = q[f*10 + 1 + i];
        byte_exp = (f == 1) ? 8'h22 : 8'h11;
        chk($sformatf("rr_byte%0d", f), {24'd0, byte_got}, {24'd0, byte_exp});
      end
    end
    @(posedge clk);
    #1;

    for (int i = 0; i < 9; i++) send_frame(vecs[i], $sformatf("v%0d", i));

    // Reset asserted during DATA bit 3 of a req0 frame of 0x00 at N=4.
    i_clks_per_bit  = 16'd4;
    i_parity_enable = 1'b0;
    i_req0_valid    = 1'b1;
    i_req0_data     = 8'h00;
    @(negedge clk);
    chk("mid_ready0", {31'd0, o_req0_ready}, 32'd1);
    @(posedge clk);
    #1;
    i_req0_valid = 1'b0;
    for (int k = 0; k < 18; k++) @(negedge clk);
    chk("mid_tx_bit3", {31'd0, o_tx}, 32'd0);
    chk("mid_busy_bit3", {31'd0, o_busy}, 32'd1);
    #1;
    rst          = 1'b1;
    i_req0_valid = 1'b1;
    i_req1_valid = 1'b1;
    #1;
    chk("mid_rst_tx", {31'd0, o_tx}, 32'd1);
    chk("mid_rst_busy", {31'd0, o_busy}, 32'd0);
    chk("mid_rst_ready0", {31'd0, o_req0_ready}, 32'd0);
    chk("mid_rst_ready1", {31'd0, o_req1_ready}, 32'd0);
    i_req0_valid = 1'b0;
    i_req1_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    rv = '{1'b1, 8'hE1, 1'b1, 8'h1E, 16'd3, 1'b1, 1'b0, 1'b0, 1'b0, 33};
    send_frame(rv, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
